master_bus_controller: RTL

Master-side sequencer for the serial shared bus: takes one parallel read/write command from a master core, wins the bus through the arbiter's request/available handshake, and serialises the 2-bit slave select, the slave-internal address and the write data bit-serially, MSB first. For reads it shifts the slave's response back into a parallel word. One instance sits between each master core (M1, M2) and the arbiter's master port.

---
 rtl/master_bus_controller.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/master_bus_controller.sv
// master_bus_controller: wins the shared bus via request/available, then serialises
// slave select, address and write data MSB first; deserialises read data.
module master_bus_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_start,
  input  logic                  req_write,
  input  logic [1:0]            req_slave,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_request,
  output logic                  m_address_valid,
  output logic                  m_valid,
  output logic                  m_address,
  output logic                  m_data,
  output logic                  m_write_en,
  output logic                  m_burst,
  input  logic                  m_available,
  input  logic                  m_ready,
  input  logic                  m_data_in,
  input  logic                  m_valid_in
);
  localparam int SW = ADDR_WIDTH + DATA_WIDTH;
  localparam int BW = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, ILLEGAL, REQ, SEL_MSB, SEL_LSB, WAIT_READY, ADDR, WDATA, RDATA, DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [1:0]            slv_q, slv_d;
  logic [SW-1:0]         sh_q, sh_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [TW-1:0]         to_q, to_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  fail;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic m_request_q, m_request_d, m_address_valid_q, m_address_valid_d;
  logic m_valid_q, m_valid_d, m_address_q, m_address_d, m_data_q, m_data_d;
  logic m_write_en_q, m_write_en_d;

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    slv_d   = slv_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    fail    = 1'b0;
    case (state_q)
      IDLE: if (req_start) begin
        // An illegal select spends one cycle in ILLEGAL so the bus is never requested.
        state_d = (req_slave == 2'd3) ? ILLEGAL : REQ;
        wr_d    = req_write;
        slv_d   = req_slave;
        sh_d    = {req_addr, req_wdata};
        bit_d   = '0;
      end
      ILLEGAL: begin
        state_d = DONE;
        fail    = 1'b1;
      end
      REQ: if (m_available) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(1)) begin
          state_d = SEL_MSB;
          bit_d   = '0;
        end
      end
      SEL_MSB: begin
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(1)) begin
          state_d = SEL_LSB;
          bit_d   = '0;
        end
      end
      SEL_LSB: begin
        state_d = WAIT_READY;
        to_d    = '0;
      end
      WAIT_READY: if (m_ready) begin
        state_d = ADDR;
        bit_d   = '0;
      end else if (m_available) begin
        to_d = to_q + 1'b1;
        if (to_q == TW'(TIMEOUT - 1)) begin
          state_d = DONE;
          fail    = 1'b1;
        end
      end
      ADDR: if (m_ready) begin
        sh_d  = {sh_q[SW-2:0], 1'b0};
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(ADDR_WIDTH - 1)) begin
          state_d = wr_q ? WDATA : RDATA;
          bit_d   = '0;
          to_d    = '0;
        end
      end
      WDATA: if (m_ready) begin
        sh_d  = {sh_q[SW-2:0], 1'b0};
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_WIDTH - 1)) state_d = DONE;
      end
      RDATA: if (m_valid_in) begin
        sh_d  = {sh_q[SW-2:0], m_data_in};
        bit_d = bit_q + 1'b1;
        to_d  = '0;
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          state_d = DONE;
          rdata_d = sh_d[DATA_WIDTH-1:0];
        end
      end else if (m_available) begin
        to_d = to_q + 1'b1;
        if (to_q == TW'(TIMEOUT - 1)) begin
          state_d = DONE;
          fail    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d            = state_d != IDLE;
    done_d            = state_d == DONE;
    error_d           = (state_d == DONE) && fail;
    m_request_d       = state_d inside {REQ, SEL_MSB, SEL_LSB, WAIT_READY, ADDR, WDATA, RDATA};
    m_address_valid_d = state_d == REQ;
    m_valid_d         = state_d inside {SEL_MSB, SEL_LSB, ADDR, WDATA};
    m_address_d       = (state_d == SEL_MSB) ? slv_d[1] :
                        (state_d == SEL_LSB) ? slv_d[0] :
                        (state_d == ADDR)    ? sh_d[SW-1] : 1'b0;
    m_data_d          = (state_d == WDATA) ? sh_d[SW-1] : 1'b0;
    m_write_en_d      = ((state_d == ADDR) && wr_d) || (state_d == WDATA);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      wr_q              <= 1'b0;
      slv_q             <= '0;
      sh_q              <= '0;
      bit_q             <= '0;
      to_q              <= '0;
      rdata_q           <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      error_q           <= 1'b0;
      m_request_q       <= 1'b0;
      m_address_valid_q <= 1'b0;
      m_valid_q         <= 1'b0;
      m_address_q       <= 1'b0;
      m_data_q          <= 1'b0;
      m_write_en_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      wr_q              <= wr_d;
      slv_q             <= slv_d;
      sh_q              <= sh_d;
      bit_q             <= bit_d;
      to_q              <= to_d;
      rdata_q           <= rdata_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      error_q           <= error_d;
      m_request_q       <= m_request_d;
      m_address_valid_q <= m_address_valid_d;
      m_valid_q         <= m_valid_d;
      m_address_q       <= m_address_d;
      m_data_q          <= m_data_d;
      m_write_en_q      <= m_write_en_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign rdata           = rdata_q;
  assign m_request       = m_request_q;
  assign m_address_valid = m_address_valid_q;
  assign m_valid         = m_valid_q;
  assign m_address       = m_address_q;
  assign m_data          = m_data_q;
  assign m_write_en      = m_write_en_q;
  assign m_burst         = 1'b0;
endmodule
